// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parameterised VGA raster timing generator (sync, active flags, coordinates, line/frame/fetch strobes)
// Ports: clk_i video clock; rst_i async active-low reset; ce_i pixel enable;
//   hs/vs sync; h_active/v_active/blank_n visible-window flags; x/y current counters;
//   line_start/frame_start/fetch_req one-cycle strobes; fetch_line row to prefetch.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CW       = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          ce_i,
  output logic          hs,
  output logic          vs,
  output logic          h_active,
  output logic          v_active,
  output logic          blank_n,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          fetch_req,
  output logic [CW-1:0] fetch_line
);
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  logic [CW-1:0] x_q, x_d, y_q, y_d, fl_q, fl_d;
  logic          hs_q, vs_q, ha_q, va_q, bn_q, ls_q, fs_q, fr_q;
  logic          h_wrap, fr_d;
  // All outputs are computed from the next counter values so they describe
  // the counters in the same cycle the counters hold them.
  always_comb begin
    h_wrap = 32'(x_q) == H_TOTAL - 1;
    x_d    = h_wrap ? '0 : x_q + 1'b1;
    y_d    = !h_wrap ? y_q : (32'(y_q) == V_TOTAL - 1 ? '0 : y_q + 1'b1);
    fl_d   = 32'(y_d) == V_TOTAL - 1 ? '0 : y_d + 1'b1;
    fr_d   = 32'(x_d) == H_ACTIVE && (32'(y_d) + 1 < V_ACTIVE || 32'(y_d) == V_TOTAL - 1);
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      x_q  <= CW'(H_TOTAL - 1);
      y_q  <= CW'(V_TOTAL - 1);
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      ha_q <= 1'b0;
      va_q <= 1'b0;
      bn_q <= 1'b0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
      fr_q <= 1'b0;
      fl_q <= '0;
    end else if (ce_i) begin
      x_q  <= x_d;
      y_q  <= y_d;
      hs_q <= (32'(x_d) >= HS_START && 32'(x_d) < HS_END) ? HS_POL : ~HS_POL;
      vs_q <= (32'(y_d) >= VS_START && 32'(y_d) < VS_END) ? VS_POL : ~VS_POL;
      ha_q <= 32'(x_d) < H_ACTIVE;
      va_q <= 32'(y_d) < V_ACTIVE;
      bn_q <= 32'(x_d) < H_ACTIVE && 32'(y_d) < V_ACTIVE;
      ls_q <= x_d == '0;
      fs_q <= x_d == '0 && y_d == '0;
      fr_q <= fr_d;
      if (fr_d) fl_q <= fl_d;
    end else begin
      ls_q <= 1'b0;
      fs_q <= 1'b0;
      fr_q <= 1'b0;
    end
  end
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign h_active    = ha_q;
  assign v_active    = va_q;
  assign blank_n     = bn_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign fetch_req   = fr_q;
  assign fetch_line  = fl_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen on a small raster (16x12 total)
module tb_vga_timing_gen;
  localparam int   HA = 8, HF = 2, HSY = 3, HB = 3;
  localparam int   VA = 6, VF = 1, VSY = 2, VB = 3;
  localparam int   HT = HA + HF + HSY + HB;
  localparam int   VT = VA + VF + VSY + VB;
  localparam int   CW = 4;
  localparam logic HP = 1'b0, VP = 1'b1;
  typedef struct packed {
    logic hs, vs, ha, va, bn;
    logic [CW-1:0] x, y;
    logic ls, fs, fr;
  } sig_t;
  typedef struct {
    sig_t s;
    logic [CW-1:0] fl;
  } exp_t;
  logic clk = 1'b0, rst_i = 1'b1, ce_i = 1'b0;
  logic hs, vs, h_active, v_active, blank_n, line_start, frame_start, fetch_req;
  logic [CW-1:0] x, y, fetch_line;
  int errors = 0, checks = 0;
  int mh, mv, cyc = 0;
  int n_fs, n_ls, n_fr, n_ha, n_hs, n_vs, n_bn, ls_bad, bad_fr, last_ls, last_fs, fs_per, ls_per;
  logic [CW-1:0] fl_first, fl_last;
  exp_t sb[$];
  always #5 clk = ~clk;
  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(HP), .VS_POL(VP), .CW(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .ce_i(ce_i),
    .hs(hs), .vs(vs), .h_active(h_active), .v_active(v_active), .blank_n(blank_n),
    .x(x), .y(y), .line_start(line_start), .frame_start(frame_start),
    .fetch_req(fetch_req), .fetch_line(fetch_line)
  );
  function automatic sig_t exp_sig(int h, int v, logic adv);
    sig_t s;
    s.hs = (h >= HA + HF && h < HA + HF + HSY) ? HP : ~HP;
    s.vs = (v >= VA + VF && v < VA + VF + VSY) ? VP : ~VP;
    s.ha = h < HA;
    s.va = v < VA;
    s.bn = h < HA && v < VA;
    s.x  = CW'(h);
    s.y  = CW'(v);
    s.ls = adv && h == 0;
    s.fs = adv && h == 0 && v == 0;
    s.fr = adv && h == HA && (v + 1 < VA || v == VT - 1);
    return s;
  endfunction
  function automatic sig_t obs_sig();
    return {hs, vs, h_active, v_active, blank_n, x, y, line_start, frame_start, fetch_req};
  endfunction
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, want, cyc);
    end
  endtask
  task automatic chk_reset(input string tag);
    check(tag, 64'(obs_sig()), 64'(exp_sig(HT - 1, VT - 1, 1'b0)));
    check({tag, "_fetch_line"}, 64'(fetch_line), 64'(0));
  endtask
  task automatic clear_stats(input int lp);
    n_fs = 0; n_ls = 0; n_fr = 0; n_ha = 0; n_hs = 0; n_vs = 0; n_bn = 0;
    ls_bad = 0; bad_fr = 0; last_ls = -1; last_fs = -1; fs_per = 0; ls_per = lp;
    fl_first = 'x; fl_last = 'x;
  endtask
  task automatic step(input logic ce);
    exp_t e;
    ce_i = ce;
    @(posedge clk);
    if (ce) begin
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else mh++;
    end
    e.s  = exp_sig(mh, mv, ce);
    e.fl = e.s.fr ? CW'(mv == VT - 1 ? 0 : mv + 1) : 'x;
    sb.push_back(e);
    @(negedge clk);
    cyc++;
    e = sb.pop_front();
    check("outputs", 64'(obs_sig()), 64'(e.s));
    if (e.s.fr) check("fetch_line", 64'(fetch_line), 64'(e.fl));
    if (ce) begin
      n_ha += int'(h_active);
      n_bn += int'(blank_n);
      n_hs += int'(hs === HP);
      n_vs += int'(vs === VP);
    end
    if (frame_start) begin
      if (last_fs >= 0) fs_per = cyc - last_fs;
      last_fs = cyc;
      n_fs++;
    end
    if (line_start) begin
      if (last_ls >= 0 && cyc - last_ls != ls_per) ls_bad++;
      last_ls = cyc;
      n_ls++;
    end
    if (fetch_req) begin
      n_fr++;
      if (int'(y) == VT - 1) fl_first = fetch_line;
      if (int'(y) == VA - 2) fl_last = fetch_line;
      if (int'(y) >= VA - 1 && int'(y) <= VT - 2) bad_fr++;
      if (int'(x) != HA) bad_fr++;
    end
  endtask
  initial begin
    ce_i = 1'b1;
    #1 rst_i = 1'b0;
    #1 chk_reset("power_on_reset");
    @(negedge clk);
    rst_i = 1'b1;
    mh = HT - 1;
    mv = VT - 1;
    clear_stats(HT);
    step(1'b1);
    check("first_frame_start", 64'({frame_start, line_start, x, y, h_active, blank_n}),
          64'({1'b1, 1'b1, CW'(0), CW'(0), 1'b1, 1'b1}));
    for (int i = 1; i < HT * VT; i++) step(1'b1);
    check("fs_count", 64'(n_fs), 64'(1));
    check("ls_count", 64'(n_ls), 64'(VT));
    check("ls_period_bad", 64'(ls_bad), 64'(0));
    check("h_active_cycles", 64'(n_ha), 64'(HA * VT));
    check("hs_pulse_cycles", 64'(n_hs), 64'(HSY * VT));
    check("vs_pulse_cycles", 64'(n_vs), 64'(VSY * HT));
    check("blank_n_cycles", 64'(n_bn), 64'(HA * VA));
    check("fetch_count", 64'(n_fr), 64'(VA));
    check("fetch_misplaced", 64'(bad_fr), 64'(0));
    check("fetch_first_line", 64'(fl_first), 64'(0));
    check("fetch_last_line", 64'(fl_last), 64'(VA - 1));
    step(1'b1);
    check("fs_period", 64'(fs_per), 64'(HT * VT));
    clear_stats(2 * HT);
    last_fs = cyc;
    for (int i = 0; i < HT * VT; i++) begin
      step(1'b0);
      step(1'b1);
    end
    check("ce_fs_period", 64'(fs_per), 64'(2 * HT * VT));
    check("ce_fs_count", 64'(n_fs), 64'(1));
    check("ce_ls_count", 64'(n_ls), 64'(VT));
    check("ce_ls_period_bad", 64'(ls_bad), 64'(0));
    check("ce_fetch_count", 64'(n_fr), 64'(VA));
    check("ce_h_active_cycles", 64'(n_ha), 64'(HA * VT));
    for (int i = 0; i < 2 * HT + 4; i++) step(1'b1);
    check("mid_frame_pos", 64'({x, y}), 64'({CW'(4), CW'(2)}));
    #2 rst_i = 1'b0;
    #1 chk_reset("async_reset");
    @(posedge clk);
    @(negedge clk);
    chk_reset("reset_held");
    rst_i = 1'b1;
    mh = HT - 1;
    mv = VT - 1;
    step(1'b1);
    check("restart_frame_start", 64'({frame_start, line_start, x, y, h_active, blank_n}),
          64'({1'b1, 1'b1, CW'(0), CW'(0), 1'b1, 1'b1}));
    for (int i = 0; i < HT + 2; i++) step(1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
